fb_pixel_writer: RTL

// - Downstream of the pixel generator: takes its (x, y, 24-bit pixel) stream, packs pixels to RGB565,

---
 rtl/fb_pixel_writer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: packs 24-bit pixels to RGB565, computes linear
// addresses y*H_RES+x and queues them as memory write requests through a
// small FIFO. Pulses frame_done after the frame's last pixel is written.
// Ports: clk, rst_n (async low); in_valid/in_ready/in_pixel/in_x/in_y pixel
// stream; mem_wr_valid/mem_wr_ready/mem_wr_addr/mem_wr_data write port;
// frame_done (1-cycle pulse); coord_err (sticky out-of-range drop flag).
module fb_pixel_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       in_pixel,
  input  logic [9:0]        in_x,
  input  logic [9:0]        in_y,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [15:0]       mem_wr_data,
  output logic              frame_done,
  output logic              coord_err
);

  localparam int LP_PW = $clog2(FIFO_DEPTH);
  localparam int LP_CW = LP_PW + 1;
  localparam logic [LP_CW-1:0] LP_FULL = LP_CW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LP_HRES = ADDR_W'(H_RES);

  typedef enum logic {
    S_RUN,
    S_DRAIN
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_addr [FIFO_DEPTH];
  logic [15:0]        r_data [FIFO_DEPTH];
  logic               r_last [FIFO_DEPTH];
  logic [LP_PW-1:0]   r_wr_ptr;
  logic [LP_PW-1:0]   r_rd_ptr;
  logic [LP_CW-1:0]   r_count;
  logic               r_frame_done;
  logic               r_coord_err;

  logic               w_in_range;
  logic               w_is_last;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [ADDR_W-1:0]  w_addr;
  logic [15:0]        w_rgb565;
  logic               w_unused_bits;

  assign w_in_range = (32'(in_x) < 32'(H_RES))
                   && (32'(in_y) < 32'(V_RES));
  assign w_is_last  = (32'(in_x) == 32'(H_RES - 1))
                   && (32'(in_y) == 32'(V_RES - 1));
  assign w_addr     = ADDR_W'(in_y) * LP_HRES
                    + ADDR_W'(in_x);
  assign w_rgb565   = {in_pixel[23:19],
                       in_pixel[15:10],
                       in_pixel[7:3]};

  // Low-order colour bits are truncated by the RGB565 packing.
  assign w_unused_bits = ^{in_pixel[18:16],
                           in_pixel[9:8],
                           in_pixel[2:0]};

  // Gated by rst_n so the stream sees not-ready during reset.
  assign in_ready = rst_n
                  & (r_state == S_RUN)
                  & (r_count < LP_FULL);

  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & w_in_range;
  assign w_pop    = mem_wr_valid & mem_wr_ready;

  assign mem_wr_valid = (r_count != '0);
  assign mem_wr_addr  = r_addr[r_rd_ptr];
  assign mem_wr_data  = r_data[r_rd_ptr];
  assign frame_done   = r_frame_done;
  assign coord_err    = r_coord_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_last[i] <= 1'b0;
      end
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_state      <= S_RUN;
      r_frame_done <= 1'b0;
      r_coord_err  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      if (w_push) begin
        r_addr[r_wr_ptr] <= w_addr;
        r_data[r_wr_ptr] <= w_rgb565;
        r_last[r_wr_ptr] <= w_is_last;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_accept && !w_in_range) begin
        r_coord_err <= 1'b1;
      end

      unique case (r_state)
        S_RUN: begin
          if (w_push && w_is_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && r_last[r_rd_ptr]) begin
            r_state      <= S_RUN;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule
